// File: rtl/execute_md_stage.sv
// Execute stage: single-cycle ALU capture plus iterative RV32M multiply/divide.
// Results are held in DONE until the memory stage accepts them.
module execute_md_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             decode_vaild_i,
  output logic             execute_allow_in_o,
  input  logic             flush_i,
  input  logic             DD_md_en_i,
  input  logic [2:0]       DD_md_op_i,
  input  logic [XLEN-1:0]  DD_rs1_data_i,
  input  logic [XLEN-1:0]  DD_rs2_data_i,
  input  logic [XLEN-1:0]  E_alu_result_i,
  input  logic [31:0]      DD_PC_i,
  input  logic             DD_need_dstE_i,
  input  logic [4:0]       DD_dstE_i,
  input  logic             memory_allow_in_i,
  output logic             execute_vaild_o,
  output logic [XLEN-1:0]  E_result_o,
  output logic [31:0]      E_PC_o,
  output logic             E_need_dstE_o,
  output logic [4:0]       E_dstE_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MUL: {partial high, remaining multiplier}; DIV: {remainder, shifting dividend/quotient}
  logic [2*XLEN-1:0]  prod_q, prod_d;
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [XLEN-1:0]    opnd_q, opnd_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic [31:0]        pc_q, pc_d;
  logic               need_q, need_d;
  logic [4:0]         dst_q, dst_d;

  logic               accept;
  logic [XLEN:0]      mul_sum;
  logic [2*XLEN-1:0]  mul_next;
  logic [2*XLEN-1:0]  mul_fixed;
  logic [XLEN:0]      div_shift;
  logic [XLEN+1:0]    div_diff;
  logic [2*XLEN-1:0]  div_next;
  logic [XLEN-1:0]    div_q, div_r;
  logic               sa, sb, div_signed;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
    return s ? (-v) : v;
  endfunction

  assign execute_allow_in_o = (state_q == IDLE) | ((state_q == DONE) & memory_allow_in_i);
  assign accept             = decode_vaild_i & execute_allow_in_o & ~flush_i;
  assign execute_vaild_o    = (state_q == DONE);
  assign busy_o             = (state_q == MUL_RUN) | (state_q == DIV_RUN);
  assign E_result_o         = res_q;
  assign E_PC_o             = pc_q;
  assign E_need_dstE_o      = need_q;
  assign E_dstE_o           = dst_q;

  // One shift-add step and one restoring-division step, both from the shared prod/opnd registers
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    mul_fixed = neg_q ? (-mul_next) : mul_next;
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (div_diff[XLEN+1]) begin
      div_next = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end
    div_q = div_next[XLEN-1:0];
    div_r = div_next[2*XLEN-1:XLEN];
  end

  // Operand signs for the incoming instruction
  always_comb begin
    div_signed = ~DD_md_op_i[0];
    if (!DD_md_op_i[2]) begin
      sa = DD_rs1_data_i[XLEN-1] & (DD_md_op_i != 3'd3);
      sb = DD_rs2_data_i[XLEN-1] & (DD_md_op_i[1] == 1'b0);
    end else begin
      sa = DD_rs1_data_i[XLEN-1] & div_signed;
      sb = DD_rs2_data_i[XLEN-1] & div_signed;
    end
  end

  // Next-state and datapath control; flush overrides everything including a same-cycle accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    pc_d    = pc_q;
    need_d  = need_q;
    dst_d   = dst_q;

    unique case (state_q)
      MUL_RUN: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = (op_q[1:0] == 2'd0) ? mul_fixed[XLEN-1:0] : mul_fixed[2*XLEN-1:XLEN];
        end
      end
      DIV_RUN: begin
        prod_d = div_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          if (op_q[1]) res_d = neg_q ? (-div_r) : div_r;
          else         res_d = neg_q ? (-div_q) : div_q;
        end
      end
      DONE: begin
        if (memory_allow_in_i) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      pc_d   = DD_PC_i;
      need_d = DD_need_dstE_i;
      dst_d  = DD_dstE_i;
      op_d   = DD_md_op_i;
      cnt_d  = '0;
      if (!DD_md_en_i) begin
        state_d = DONE;
        res_d   = E_alu_result_i;
      end else if (!DD_md_op_i[2]) begin
        state_d = MUL_RUN;
        prod_d  = {{XLEN{1'b0}}, mag(DD_rs2_data_i, sb)};
        opnd_d  = mag(DD_rs1_data_i, sa);
        neg_d   = sa ^ sb;
      end else if (DD_rs2_data_i == '0) begin
        state_d = DONE;
        res_d   = DD_md_op_i[1] ? DD_rs1_data_i : '1;
      end else if (div_signed && DD_rs1_data_i == MIN_INT && DD_rs2_data_i == '1) begin
        state_d = DONE;
        res_d   = DD_md_op_i[1] ? '0 : MIN_INT;
      end else begin
        state_d = DIV_RUN;
        prod_d  = {{XLEN{1'b0}}, mag(DD_rs1_data_i, sa)};
        opnd_d  = mag(DD_rs2_data_i, sb);
        neg_d   = DD_md_op_i[1] ? sa : (sa ^ sb);
      end
    end

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      need_d  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      pc_q    <= '0;
      need_q  <= 1'b0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      pc_q    <= pc_d;
      need_q  <= need_d;
      dst_q   <= dst_d;
    end
  end

endmodule
